// File: rtl/sopc_system_nios2_qsys_0_ocimem_sequencer.sv
// JTAG debug memory sequencer: turns ocimem command pulses into single
// memory-master reads/writes with waitrequest handling and a stall timeout.
module sopc_system_nios2_qsys_0_ocimem_sequencer #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  input  logic [31:0]       mem_readdata,
  input  logic              mem_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic [1:0]        dbg_state
);

  // Memory handshake: a request (mem_read or mem_write) completes on the first
  // rising edge that samples mem_waitrequest low while the request is high.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_L = 8'(TIMEOUT);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       mon_q, mon_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              err_set, err_clr, any_cmd;
  logic              unused_jdo;

  assign any_cmd    = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    mon_d   = mon_q;
    wdata_d = wdata_q;
    ready_d = ready_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    err_set = 1'b0;
    err_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (take_action_ocimem_a) begin
          addr_d  = jdo[10 +: ADDR_W];
          err_clr = jdo[34];
          if (jdo[35]) begin
            state_d = READ;
            ready_d = 1'b0;
            cnt_d   = 8'd0;
          end
        end else if (take_action_ocimem_b) begin
          wdata_d = jdo[34:3];
          ready_d = 1'b0;
          state_d = WRITE;
          cnt_d   = 8'd0;
        end else if (take_no_action_ocimem_a) begin
          ready_d = 1'b0;
          state_d = READ;
          cnt_d   = 8'd0;
        end
      end
      READ, WRITE: begin
        err_set = any_cmd;
        if (!(rd_q || wr_q)) begin
          // first cycle after entry: raise the request
          rd_d = (state_q == READ);
          wr_d = (state_q == WRITE);
        end else if (!mem_waitrequest) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          ready_d = 1'b1;
          addr_d  = addr_q + ADDR_W'(1);
          if (state_q == READ) mon_d = mem_readdata;
          state_d = IDLE;
        end else if (cnt_q + 8'd1 == TIMEOUT_L) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          ready_d = 1'b1;
          err_set = 1'b1;
          cnt_d   = cnt_q + 8'd1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    err_d = (err_q | err_set) & ~err_clr;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      mon_q   <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      mon_q   <= mon_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_address   = addr_q;
  assign mem_read      = rd_q;
  assign mem_write     = wr_q;
  assign mem_writedata = wdata_q;
  assign MonDReg       = mon_q;
  assign monitor_ready = ready_q;
  assign monitor_error = err_q;
  assign dbg_state     = state_q;

endmodule
